mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the EX stage

---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at issue and held until a fixed busy period expires, which models multi-cycle latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    function automatic logic [63:0] f_mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        ax = a;
        bx = b;
        return ax * bx;
    endfunction

    function automatic logic [63:0] f_mul_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {32'd0, a};
        bx = {32'd0, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; a zero divisor is forced to 1 so no X is produced.
    function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bd;
        bd = (b == 32'd0) ? 32'd1 : b;
        return {a % bd, a / bd};
    endfunction

    // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000, remainder 0).
    function automatic logic [63:0] f_div_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        ua = a[31] ? (~a + 32'd1) : a;
        ub = b[31] ? (~b + 32'd1) : b;
        if (ub == 32'd0) ub = 32'd1;
        q = ua / ub;
        r = ua % ub;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31]) r = ~r + 32'd1;
        return {r, q};
    endfunction

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_res;
    logic             r_wr_en;

    logic [63:0]      w_res;
    logic             w_divz;
    logic             w_is_md;
    logic             w_accept;
    logic [CNT_W-1:0] w_load;

    always_comb begin
        w_res   = 64'd0;
        w_divz  = 1'b0;
        w_is_md = 1'b0;
        w_load  = MUL_LOAD;
        case (MDUOp)
            OP_MULT:  begin w_res = f_mul_s(SrcA, SrcB); w_is_md = 1'b1; end
            OP_MULTU: begin w_res = f_mul_u(SrcA, SrcB); w_is_md = 1'b1; end
            OP_DIV: begin
                w_res   = f_div_s(SrcA, SrcB);
                w_divz  = (SrcB == 32'd0);
                w_is_md = 1'b1;
                w_load  = DIV_LOAD;
            end
            OP_DIVU: begin
                w_res   = f_div_u(SrcA, SrcB);
                w_divz  = (SrcB == 32'd0);
                w_is_md = 1'b1;
                w_load  = DIV_LOAD;
            end
            default: ;
        endcase
    end

    assign w_accept = start && (r_state == S_IDLE) && w_is_md;

    // Issue stage: result captured here, released to HI/LO when the counter expires
    always_ff @(posedge clk) begin
        if (w_accept) r_res <= w_res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= w_load;
                        r_wr_en <= ~w_divz;
                        busy    <= 1'b1;
                        r_state <= S_BUSY;
                    end else if (start && MDUOp == OP_MTHI) begin
                        HI <= SrcA;
                    end else if (start && MDUOp == OP_MTLO) begin
                        LO <= SrcA;
                    end
                end
                default: begin
                    if (r_cnt == '0) begin
                        if (r_wr_en) begin
                            HI <= r_res[63:32];
                            LO <= r_res[31:0];
                        end
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  MDUOp = OP_NONE;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called in the first busy cycle; returns in the cycle done should be high.
    task automatic wait_busy(input string tag, input int exp_cyc);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int n;
        int bad;
        hi0 = HI;
        lo0 = LO;
        n = 0;
        bad = 0;
        while (busy === 1'b1 && n < 100) begin
            if (done !== 1'b0 || HI !== hi0 || LO !== lo0) bad = 1;
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, n, exp_cyc);
        check({tag, "_hold"}, bad, 0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDUOp = op;
        SrcA  = a;
        SrcB  = b;
        tick();
        start = 1'b0;
        MDUOp = OP_NONE;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        wait_busy(tag, cyc);
        check({tag, "_HI"}, HI, exp_hi);
        check({tag, "_LO"}, LO, exp_lo);
        tick();
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int bad;

        // reset and mthi
        reset = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        reset = 1'b0;
        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_HI", HI, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_done", {31'd0, done}, 32'd0);

        // multiply
        run_md("mult", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);

        // divide
        run_md("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        issue(OP_MTHI, 32'h0000_00AA, 32'd0);
        issue(OP_MTLO, 32'h0000_00BB, 32'd0);
        run_md("div_zero", OP_DIV, 32'd5, 32'd0, 10, 32'h0000_00AA, 32'h0000_00BB);

        // mtlo while busy is ignored
        issue(OP_MULT, 32'd3, 32'd4);
        issue(OP_MTLO, 32'h0000_DEAD, 32'd0);
        check("mtlo_busy_LO", LO, 32'h0000_00BB);
        wait_busy("mult_mtlo", 4);
        check("mult_mtlo_HI", HI, 32'd0);
        check("mult_mtlo_LO", LO, 32'd12);
        tick();

        // reset in the middle of a divide
        issue(OP_DIV, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_HI", HI, 32'd0);
        check("abort_LO", LO, 32'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad = 1;
        end
        check("abort_no_late_write", bad, 0);

        // back-to-back: divu issued in the done cycle of a mult
        issue(OP_MULT, 32'd5, 32'd6);
        wait_busy("b2b_mult", 5);
        check("b2b_mult_LO", LO, 32'd30);
        issue(OP_DIVU, 32'd100, 32'd7);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        check("b2b_hold_HI", HI, 32'd0);
        check("b2b_hold_LO", LO, 32'd30);
        wait_busy("b2b_divu", 10);
        check("b2b_divu_HI", HI, 32'd2);
        check("b2b_divu_LO", LO, 32'd14);
        n = 0;
        tick();
        if (done !== 1'b0) n = 1;
        check("b2b_done_once", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
